// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// =============================================================================
// Module      : pc_fetch_pkg
// Description : Shared fetch-stage constants: PC-select encodings, fetch FSM
//               states and word-alignment helper.
// Revision    : 1.0 - initial release
// =============================================================================
package pc_fetch_pkg;

    localparam int XLEN = 32;

    // The same encodings are driven by the branch unit in execute.
    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_JALR = 2'b01;
    localparam logic [1:0] PCSEL_TGT  = 2'b11;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_buf.sv
`default_nettype none
// =============================================================================
// Module      : pc_fetch_buf
// Description : One-entry valid/ready output buffer between fetch and decode,
//               with a kill input that overrides load and consume.
// Revision    : 1.0 - initial release
// =============================================================================
module pc_fetch_buf
    import pc_fetch_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_kill,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_inst,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Payload only changes on load, so it stays stable while decode stalls.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (i_kill) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            inst_d  = i_load_inst;
            pc_d    = i_load_pc;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_inst  = inst_q;
    assign o_pc    = pc_q;

endmodule
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// =============================================================================
// Module      : pc_fetch
// Description : Fetch-stage PC generator and single-outstanding instruction
//               fetch controller with redirect-driven wrong-path discard.
// Revision    : 1.0 - initial release
// =============================================================================
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [1:0]      i_pc_sel,
    input  logic [XLEN-1:0] i_target,
    input  logic [XLEN-1:0] i_jalr_target,
    output logic            o_flush,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_inst_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_inst_ready
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            req;
    logic            buf_load;
    logic            buf_valid;
    logic [XLEN-1:0] buf_inst;
    logic [XLEN-1:0] buf_pc;

    assign redirect    = (i_pc_sel == PCSEL_TGT) || (i_pc_sel == PCSEL_JALR);
    assign redirect_pc = word_align((i_pc_sel == PCSEL_TGT) ? i_target : i_jalr_target);

    // A new fetch may only start if its result has somewhere to land next cycle.
    assign req = i_rst_n && (state_q == S_REQ) && (!buf_valid || i_inst_ready) && !redirect;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        buf_load   = 1'b0;
        case (state_q)
            S_REQ: begin
                if (req && i_imem_gnt) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + XLEN'(4);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    buf_load = 1'b1;
                    state_d  = S_REQ;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (i_imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        // Redirect wins; the buffer kill below discards any coincident load.
        if (redirect) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_ADDR;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    pc_fetch_buf u_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_kill      (redirect),
        .i_load      (buf_load),
        .i_load_inst (i_imem_rdata),
        .i_load_pc   (fetch_pc_q),
        .i_ready     (i_inst_ready),
        .o_valid     (buf_valid),
        .o_inst      (buf_inst),
        .o_pc        (buf_pc)
    );

    // Outputs are forced to reset values while reset is held, before the first edge.
    assign o_flush      = redirect;
    assign o_imem_req   = req;
    assign o_imem_addr  = i_rst_n ? pc_q : RESET_ADDR;
    assign o_inst_valid = i_rst_n && buf_valid;
    assign o_inst       = i_rst_n ? buf_inst : '0;
    assign o_inst_pc    = i_rst_n ? buf_pc : '0;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// =============================================================================
// Module      : tb_pc_fetch
// Description : Self-checking bench for pc_fetch with a latency-programmable
//               memory model and expected-address / expected-PC scoreboards.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_pc_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [1:0]  i_pc_sel;
    logic [31:0] i_target;
    logic [31:0] i_jalr_target;
    logic        o_flush;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;

    pc_fetch #(.RESET_ADDR(32'h0000_0000)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pc_sel      (i_pc_sel),
        .i_target      (i_target),
        .i_jalr_target (i_jalr_target),
        .o_flush       (o_flush),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .i_inst_ready  (i_inst_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];

    int          lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    logic        obs_req, obs_gnt, obs_valid, obs_rvalid;
    logic [31:0] obs_addr, obs_inst, obs_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive memory/grant, sample at negedge+1, score, advance.
    task automatic cycle();
        logic [31:0] e;
        if (mem_busy && mem_cnt == 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(mem_addr);
            mem_busy      = 1'b0;
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = 32'h0;
            if (mem_busy) mem_cnt--;
        end
        i_imem_gnt = (exp_addr_q.size() != 0);
        #1;
        obs_rvalid = i_imem_rvalid;
        obs_req    = o_imem_req;
        obs_gnt    = o_imem_req && i_imem_gnt;
        obs_addr   = o_imem_addr;
        obs_valid  = o_inst_valid;
        obs_inst   = o_inst;
        obs_pc     = o_inst_pc;
        check_eq("flush", 32'(o_flush), 32'((i_pc_sel == 2'b11) || (i_pc_sel == 2'b01)));
        if (obs_gnt) begin
            if (exp_addr_q.size() != 0) begin
                e = exp_addr_q.pop_front();
                check_eq("req_addr", o_imem_addr, e);
            end else begin
                check_eq("req_unexpected", o_imem_addr, 32'hDEAD_DEAD);
            end
            mem_busy = 1'b1;
            mem_addr = o_imem_addr;
            mem_cnt  = lat - 1;
        end
        if (o_inst_valid && i_inst_ready) begin
            if (exp_pc_q.size() != 0) begin
                e = exp_pc_q.pop_front();
                check_eq("inst_pc", o_inst_pc, e);
                check_eq("inst_word", o_inst, mem_word(e));
            end else begin
                check_eq("inst_unexpected", o_inst_pc, 32'hDEAD_DEAD);
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic run_idle(input string tag);
        int n = 0;
        while ((exp_addr_q.size() != 0 || exp_pc_q.size() != 0 || mem_busy) && n < 200) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(exp_addr_q.size() + exp_pc_q.size()), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   32'(obs_req), 32'h0);
        check_eq({tag, "_valid"}, 32'(obs_valid), 32'h0);
        check_eq({tag, "_inst"},  obs_inst, 32'h0);
        check_eq({tag, "_pc"},    obs_pc, 32'h0);
        check_eq({tag, "_addr"},  obs_addr, 32'h0);
    endtask

    initial begin
        logic [5:0] gnt_pat;
        logic       saw_rv;
        i_rst_n       = 1'b0;
        i_pc_sel      = 2'b00;
        i_target      = '0;
        i_jalr_target = '0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        i_inst_ready  = 1'b1;
        @(negedge i_clk);

        // Reset state
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_reset_outputs("rst");
        end

        // Sequential fetch, 1-cycle memory: grants on alternating cycles
        i_rst_n = 1'b1;
        lat     = 1;
        exp_addr_q = '{32'h0, 32'h4, 32'h8};
        exp_pc_q   = '{32'h0, 32'h4, 32'h8};
        gnt_pat = 6'b010101;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_eq("seq_gnt_pattern", 32'(obs_gnt), 32'(gnt_pat[i]));
        end
        run_idle("seq_drain");

        // Branch redirect while waiting; stale response 3 cycles later is dropped
        lat = 4;
        exp_addr_q = '{32'hC, 32'h100};
        exp_pc_q   = '{32'h100};
        cycle();
        check_eq("br_grant", 32'(obs_gnt), 32'h1);
        i_pc_sel = 2'b11;
        i_target = 32'h100;
        cycle();
        i_pc_sel = 2'b00;
        saw_rv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("br_drop_noreq", 32'(obs_req), 32'h0);
            saw_rv = saw_rv | obs_rvalid;
        end
        check_eq("br_stale_rvalid", 32'(saw_rv), 32'h1);
        run_idle("br_drain");

        // JALR redirect clears low bits; pc_sel=10 behaves as sequential
        lat = 1;
        i_pc_sel      = 2'b01;
        i_jalr_target = 32'h203;
        cycle();
        check_eq("jalr_req_forced_low", 32'(obs_req), 32'h0);
        i_pc_sel = 2'b10;
        exp_addr_q = '{32'h200, 32'h204};
        exp_pc_q   = '{32'h200, 32'h204};
        run_idle("jalr_drain");
        i_pc_sel = 2'b00;

        // Decode stall: buffer full, no requests, stable payload
        i_inst_ready = 1'b0;
        exp_addr_q = '{32'h208};
        exp_pc_q   = '{32'h208};
        cycle();
        cycle();
        exp_addr_q.push_back(32'h20C);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("stall_noreq", 32'(obs_req), 32'h0);
            check_eq("stall_valid", 32'(obs_valid), 32'h1);
            check_eq("stall_inst", obs_inst, mem_word(32'h208));
            check_eq("stall_pc", obs_pc, 32'h208);
        end
        i_inst_ready = 1'b1;
        exp_pc_q.push_back(32'h20C);
        cycle();
        check_eq("stall_release_gnt", 32'(obs_gnt), 32'h1);
        run_idle("stall_drain");

        // Redirect coincident with rvalid and decode ready
        lat = 2;
        exp_addr_q = '{32'h210};
        cycle();
        cycle();
        i_pc_sel = 2'b11;
        i_target = 32'h300;
        cycle();
        check_eq("coinc_rvalid", 32'(obs_rvalid), 32'h1);
        i_pc_sel = 2'b00;
        cycle();
        check_eq("coinc_buf_invalid", 32'(obs_valid), 32'h0);
        check_eq("coinc_state_req", 32'(obs_req), 32'h1);
        check_eq("coinc_pc_target", obs_addr, 32'h300);

        // Reset during outstanding request; stale rvalid lands inside reset
        lat = 3;
        exp_addr_q = '{32'h300};
        cycle();
        i_rst_n = 1'b0;
        saw_rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_reset_outputs("rst_mid");
            saw_rv = saw_rv | obs_rvalid;
        end
        check_eq("rst_stale_rvalid", 32'(saw_rv), 32'h1);
        i_rst_n = 1'b1;
        lat = 1;
        exp_addr_q = '{32'h0};
        exp_pc_q   = '{32'h0};
        cycle();
        check_eq("rst_first_gnt", 32'(obs_gnt), 32'h1);
        run_idle("rst_drain");

        // Address wrap at top of memory
        i_pc_sel      = 2'b01;
        i_jalr_target = 32'hFFFF_FFFF;
        cycle();
        i_pc_sel = 2'b00;
        exp_addr_q = '{32'hFFFF_FFFC, 32'h0};
        exp_pc_q   = '{32'hFFFF_FFFC, 32'h0};
        run_idle("wrap_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
